// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM and
// registered one-cycle strobes for a good byte (rx_dv) or a bad stop bit (rx_frame_err).
module uart_rx #(
  parameter int FREQUENCY = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_dv,
  output logic       rx_frame_err,
  output logic       rx_active
);

  localparam int CLKS_PER_BIT = FREQUENCY / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_dv_q, rx_dv_d;
  logic            rx_frame_err_q, rx_frame_err_d;
  logic            rx_active_q, rx_active_d;
  logic            rx_meta_q, rx_s_q;
  logic            stop_sample_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      clk_cnt_q      <= CNT_ZERO;
      bit_idx_q      <= 3'd0;
      shift_q        <= 8'h00;
      rx_byte_q      <= 8'h00;
      rx_dv_q        <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_active_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      clk_cnt_q      <= clk_cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_byte_q      <= rx_byte_d;
      rx_dv_q        <= rx_dv_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_active_q    <= rx_active_d;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = CNT_ZERO;
        bit_idx_d = 3'd0;
        if (!rx_s_q) state_d = ST_START;
        else         state_d = ST_IDLE;
      end
      ST_START: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (clk_cnt_q == CNT_HALF_END) begin
          clk_cnt_d = CNT_ZERO;
          if (rx_s_q) state_d = ST_IDLE;
          else        state_d = ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CNT_BIT_END) begin
          clk_cnt_d          = CNT_ZERO;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            bit_idx_d = 3'd0;
            state_d   = ST_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == CNT_BIT_END) begin
          clk_cnt_d = CNT_ZERO;
          state_d   = ST_CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      ST_CLEANUP: begin
        // Wait for the line to return high so a held-low break cannot retrigger.
        clk_cnt_d = CNT_ZERO;
        if (rx_s_q) state_d = ST_IDLE;
        else        state_d = ST_CLEANUP;
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = CNT_ZERO;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  assign stop_sample_s = (state_q == ST_STOP) && (clk_cnt_q == CNT_BIT_END);

  // Output decode, registered alongside the state so strobes and rx_active move together.
  always_comb begin
    rx_byte_d      = rx_byte_q;
    rx_dv_d        = 1'b0;
    rx_frame_err_d = 1'b0;
    rx_active_d    = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
    if (stop_sample_s) begin
      if (rx_s_q) begin
        rx_byte_d = shift_q;
        rx_dv_d   = 1'b1;
      end else begin
        rx_frame_err_d = 1'b1;
      end
    end else begin
      rx_dv_d        = 1'b0;
      rx_frame_err_d = 1'b0;
    end
  end

  assign rx_byte      = rx_byte_q;
  assign rx_dv        = rx_dv_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_active    = rx_active_q;

endmodule
